// File: rtl/oled_spi_cmd_tx_pkg.sv
// Shared types and constants for the OLED SPI command serialiser.
package oled_spi_cmd_tx_pkg;

  // Frame sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_NEXT  = 3'd4,
    ST_HOLD  = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  localparam logic SPI_IDLE_SCLK = 1'b1;
  localparam logic DC_CMD        = 1'b0;
  localparam logic DC_DATA       = 1'b1;

  // CS setup/hold timer width; supports CS_SETUP/CS_HOLD up to 255.
  localparam int TMR_W = 8;

  // Frame sequencer registers, grouped so the whole FSM context can be probed at once.
  typedef struct packed {
    state_t           state;
    logic [TMR_W-1:0] tmr;
    logic [3:0]       byte_cnt;
    logic             last;
    logic             forced;
  } frame_t;

  localparam frame_t FRAME_RST = '{
    state:    ST_IDLE,
    tmr:      '0,
    byte_cnt: '0,
    last:     1'b0,
    forced:   1'b0
  };

  // Terminal value of a count that must last 'cycles' clock cycles.
  function automatic logic [TMR_W-1:0] tmr_last(input int unsigned cycles);
    return TMR_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/oled_spi_cmd_tx_shifter.sv
// One-byte SPI mode 3 shifter: MSB first, data changes with the SCLK fall,
// panel samples on the rise. SCLK rests high whenever no byte is in flight.
module oled_spi_cmd_tx_shifter
  import oled_spi_cmd_tx_pkg::*;
#(
  parameter int unsigned CLK_DIV = 5
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_load,
  input  logic [7:0] i_data,
  output logic       o_sclk,
  output logic       o_mosi,
  output logic       o_byte_done
);

  localparam int HALF_W = $clog2(CLK_DIV + 1);
  localparam logic [HALF_W-1:0] HALF_END = HALF_W'(CLK_DIV - 1);

  // mosi_q carries the bit on the wire; shreg_q holds the bits still to send.
  logic [6:0]        shreg_q, shreg_d;
  logic              mosi_q, mosi_d;
  logic              sclk_q, sclk_d;
  logic [HALF_W-1:0] half_q, half_d;
  logic [2:0]        bit_q, bit_d;
  logic              active_q, active_d;
  logic              half_end;

  assign half_end    = (half_q == HALF_END);
  // Last cycle of bit 0's high half: the byte is fully on the wire.
  assign o_byte_done = active_q & sclk_q & half_end & (bit_q == 3'd7);
  assign o_sclk      = sclk_q;
  assign o_mosi      = mosi_q;

  // Next-state: load falls SCLK with MSB; each half-period end toggles SCLK, each fall shifts.
  always_comb begin
    shreg_d  = shreg_q;
    mosi_d   = mosi_q;
    sclk_d   = sclk_q;
    half_d   = half_q;
    bit_d    = bit_q;
    active_d = active_q;
    if (i_load) begin
      shreg_d  = i_data[6:0];
      mosi_d   = i_data[7];
      sclk_d   = 1'b0;
      half_d   = '0;
      bit_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (!half_end) begin
        half_d = half_q + HALF_W'(1);
      end else begin
        half_d = '0;
        if (!sclk_q) begin
          sclk_d = 1'b1;
        end else if (bit_q == 3'd7) begin
          active_d = 1'b0;
        end else begin
          sclk_d  = 1'b0;
          mosi_d  = shreg_q[6];
          shreg_d = {shreg_q[5:0], 1'b0};
          bit_d   = bit_q + 3'd1;
        end
      end
    end
  end

  // Shifter registers; reset parks SCLK at its idle level.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      shreg_q  <= '0;
      mosi_q   <= 1'b0;
      sclk_q   <= SPI_IDLE_SCLK;
      half_q   <= '0;
      bit_q    <= '0;
      active_q <= 1'b0;
    end else begin
      shreg_q  <= shreg_d;
      mosi_q   <= mosi_d;
      sclk_q   <= sclk_d;
      half_q   <= half_d;
      bit_q    <= bit_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/oled_spi_cmd_tx.sv
// Frame sequencer for the SSD1331 command path: frames a byte stream from the
// command buffer in CS, fixes D/C for the frame and paces the buffer.
module oled_spi_cmd_tx
  import oled_spi_cmd_tx_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 5,
  parameter int unsigned CS_SETUP  = 2,
  parameter int unsigned CS_HOLD   = 2,
  parameter int unsigned MAX_BYTES = 15
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic       i_dc,
  input  logic [7:0] i_byte,
  input  logic       i_last_byte,
  output logic       o_next_byte,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_overrun,
  output logic       o_sclk,
  output logic       o_mosi,
  output logic       o_cs_n,
  output logic       o_dc
);

  // Buffer handshake: i_byte/i_last_byte are treated as always valid and are
  // sampled only in LOAD. o_next_byte is the single-cycle "consumed" strobe;
  // the buffer advances on the edge ending that cycle, so the next LOAD sees
  // the new byte. It is never raised for the byte that closes the frame.

  frame_t fr_q, fr_d;
  logic   cs_n_q, cs_n_d;
  logic   busy_q, busy_d;
  logic   dc_q, dc_d;
  logic   next_q, next_d;
  logic   done_q, done_d;
  logic   ovr_q, ovr_d;
  logic   load;
  logic   byte_done;
  logic   at_limit;

  assign at_limit = (fr_q.byte_cnt == 4'(MAX_BYTES - 1));

  oled_spi_cmd_tx_shifter #(
    .CLK_DIV(CLK_DIV)
  ) u_shifter (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (load),
    .i_data     (i_byte),
    .o_sclk     (o_sclk),
    .o_mosi     (o_mosi),
    .o_byte_done(byte_done)
  );

  // Next-state and registered-output values for the frame sequencer.
  always_comb begin
    fr_d   = fr_q;
    cs_n_d = cs_n_q;
    busy_d = busy_q;
    dc_d   = dc_q;
    next_d = 1'b0;
    done_d = 1'b0;
    ovr_d  = 1'b0;
    load   = 1'b0;
    unique case (fr_q.state)
      ST_IDLE: begin
        if (i_start) begin
          dc_d          = i_dc;
          cs_n_d        = 1'b0;
          busy_d        = 1'b1;
          fr_d.byte_cnt = '0;
          fr_d.tmr      = '0;
          fr_d.last     = 1'b0;
          fr_d.forced   = 1'b0;
          fr_d.state    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (fr_q.tmr == tmr_last(CS_SETUP)) fr_d.state = ST_LOAD;
        else                                fr_d.tmr   = fr_q.tmr + TMR_W'(1);
      end
      ST_LOAD: begin
        load          = 1'b1;
        fr_d.last     = i_last_byte | at_limit;
        // Overrun only when the limit, not the buffer, ended the frame.
        fr_d.forced   = ~i_last_byte & at_limit;
        fr_d.byte_cnt = fr_q.byte_cnt + 4'd1;
        fr_d.state    = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (byte_done) begin
          if (fr_q.last) begin
            fr_d.tmr   = '0;
            fr_d.state = ST_HOLD;
          end else begin
            next_d     = 1'b1;
            fr_d.state = ST_NEXT;
          end
        end
      end
      ST_NEXT: begin
        fr_d.state = ST_LOAD;
      end
      ST_HOLD: begin
        if (fr_q.tmr == tmr_last(CS_HOLD)) begin
          cs_n_d     = 1'b1;
          done_d     = 1'b1;
          ovr_d      = fr_q.forced;
          fr_d.state = ST_DONE;
        end else begin
          fr_d.tmr = fr_q.tmr + TMR_W'(1);
        end
      end
      ST_DONE: begin
        busy_d     = 1'b0;
        fr_d.state = ST_IDLE;
      end
      default: begin
        fr_d = FRAME_RST;
      end
    endcase
  end

  // Sequencer state and registered outputs; reset aborts any frame silently.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      fr_q   <= FRAME_RST;
      cs_n_q <= 1'b1;
      busy_q <= 1'b0;
      dc_q   <= DC_CMD;
      next_q <= 1'b0;
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      fr_q   <= fr_d;
      cs_n_q <= cs_n_d;
      busy_q <= busy_d;
      dc_q   <= dc_d;
      next_q <= next_d;
      done_q <= done_d;
      ovr_q  <= ovr_d;
    end
  end

  assign o_cs_n      = cs_n_q;
  assign o_busy      = busy_q;
  assign o_dc        = dc_q;
  assign o_next_byte = next_q;
  assign o_done      = done_q;
  assign o_overrun   = ovr_q;

endmodule

// File: tb/tb_oled_spi_cmd_tx.sv
// Bench for oled_spi_cmd_tx: two instances (CLK_DIV=2 and CLK_DIV=1, both with
// CS_SETUP=CS_HOLD=1, MAX_BYTES=4) behind an output select, a command buffer model,
// a wire-level SPI monitor and a byte scoreboard.
module tb_oled_spi_cmd_tx;
  import oled_spi_cmd_tx_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       i_reset = 1'b1;
  logic       i_start = 1'b0;
  logic       i_dc    = 1'b0;
  logic [7:0] i_byte;
  logic       i_last_byte;

  logic a_nb, a_busy, a_done, a_ovr, a_sclk, a_mosi, a_cs_n, a_dc;
  logic b_nb, b_busy, b_done, b_ovr, b_sclk, b_mosi, b_cs_n, b_dc;

  oled_spi_cmd_tx #(.CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(1), .MAX_BYTES(4)) u_dut_a (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_dc(i_dc),
    .i_byte(i_byte), .i_last_byte(i_last_byte),
    .o_next_byte(a_nb), .o_busy(a_busy), .o_done(a_done), .o_overrun(a_ovr),
    .o_sclk(a_sclk), .o_mosi(a_mosi), .o_cs_n(a_cs_n), .o_dc(a_dc)
  );

  oled_spi_cmd_tx #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .MAX_BYTES(4)) u_dut_b (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_dc(i_dc),
    .i_byte(i_byte), .i_last_byte(i_last_byte),
    .o_next_byte(b_nb), .o_busy(b_busy), .o_done(b_done), .o_overrun(b_ovr),
    .o_sclk(b_sclk), .o_mosi(b_mosi), .o_cs_n(b_cs_n), .o_dc(b_dc)
  );

  // Observed instance select (0 = CLK_DIV 2, 1 = CLK_DIV 1).
  logic sel = 1'b0;
  logic nb, busy, done, ovr, sclk, mosi, cs_n, dc;
  assign nb   = sel ? b_nb   : a_nb;
  assign busy = sel ? b_busy : a_busy;
  assign done = sel ? b_done : a_done;
  assign ovr  = sel ? b_ovr  : a_ovr;
  assign sclk = sel ? b_sclk : a_sclk;
  assign mosi = sel ? b_mosi : a_mosi;
  assign cs_n = sel ? b_cs_n : a_cs_n;
  assign dc   = sel ? b_dc   : a_dc;

  // ---------------- command buffer model ----------------
  logic [7:0] buf_mem [16];
  int         buf_num  = 1;
  logic       buf_tie0 = 1'b0;
  int         nb_total = 0;
  int         nb_base  = 0;
  int         buf_idx;

  always @(posedge clk) if (nb === 1'b1) nb_total <= nb_total + 1;

  assign buf_idx     = ((nb_total - nb_base) > 15) ? 15 : (nb_total - nb_base);
  assign i_byte      = buf_mem[buf_idx[3:0]];
  assign i_last_byte = !buf_tie0 && (buf_idx == buf_num - 1);

  // ---------------- SPI monitor ----------------
  int         cs_low_cnt = 0, next_cnt = 0, done_cnt = 0, ovr_cnt = 0, viol_cnt = 0, rise_total = 0;
  int         bit_n = 0;
  logic [7:0] bit_sr = 8'h00;
  logic [7:0] cap_q[$];
  logic       prev_sclk = 1'b1, prev_mosi = 1'b0, prev_cs_n = 1'b1, prev_dc = 1'b0;

  always @(negedge clk) begin
    if (cs_n === 1'b0) begin
      cs_low_cnt++;
      if (prev_sclk === 1'b0 && sclk === 1'b1) begin
        bit_sr = {bit_sr[6:0], mosi};
        bit_n++;
        rise_total++;
        if (bit_n == 8) begin
          cap_q.push_back(bit_sr);
          bit_n = 0;
        end
      end
      // Mode 3: data may move only together with a falling SCLK.
      if (mosi !== prev_mosi && !(prev_sclk === 1'b1 && sclk === 1'b0)) viol_cnt++;
      if (prev_cs_n === 1'b0 && dc !== prev_dc) viol_cnt++;
    end else begin
      bit_n = 0;
      if (sclk !== SPI_IDLE_SCLK) viol_cnt++;
    end
    if (nb === 1'b1) next_cnt++;
    if (nb === 1'b1 && cs_n !== 1'b0) viol_cnt++;
    if (done === 1'b1) done_cnt++;
    if (ovr === 1'b1) ovr_cnt++;
    if (ovr === 1'b1 && done !== 1'b1) viol_cnt++;
    prev_sclk = sclk;
    prev_mosi = mosi;
    prev_cs_n = cs_n;
    prev_dc   = dc;
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int n_vec = 0;
  int errs  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        sel;
    logic        dc;
    logic        tie0;
    logic        poke;
    int          n_in;
    logic [39:0] b;          // byte k at b[8k +: 8]
    int          exp_bytes;
    int          exp_lat;    // cycles from the i_start cycle to the o_done cycle, inclusive
    int          exp_cs_low;
    int          exp_next;
    logic        exp_ovr;
  } vec_t;

  vec_t vecs[5];

  function automatic vec_t mk(input logic s, input logic d, input logic t0, input logic pk,
                              input int n, input logic [39:0] b, input int eb, input int el,
                              input int ec, input int en, input logic eo);
    vec_t v;
    v.sel = s; v.dc = d; v.tie0 = t0; v.poke = pk; v.n_in = n; v.b = b;
    v.exp_bytes = eb; v.exp_lat = el; v.exp_cs_low = ec; v.exp_next = en; v.exp_ovr = eo;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load_vec(input int i);
    vec_t v = vecs[i];
    sel      = v.sel;
    buf_num  = v.n_in;
    buf_tie0 = v.tie0;
    nb_base  = nb_total;
    for (int k = 0; k < 16; k++) buf_mem[k] = (k < 5) ? v.b[8*k +: 8] : 8'h00;
    exp_q.delete();
    cap_q.delete();
    for (int k = 0; k < v.exp_bytes; k++) exp_q.push_back(v.b[8*k +: 8]);
  endtask

  task automatic run_frame(input int i);
    vec_t v = vecs[i];
    int   cyc, idle_bad;
    int   s_cs, s_nb, s_done, s_ovr, s_viol;
    logic [7:0] e, c;
    load_vec(i);
    s_cs = cs_low_cnt; s_nb = next_cnt; s_done = done_cnt; s_ovr = ovr_cnt; s_viol = viol_cnt;
    @(negedge clk);
    i_start = 1'b1;
    i_dc    = v.dc;
    cyc     = 1;
    while (1) begin
      @(negedge clk);
      cyc++;
      i_start = v.poke && (cyc == 10);
      i_dc    = (v.poke && cyc == 10) ? ~v.dc : v.dc;
      if (done === 1'b1 || cyc > 3000) break;
    end
    i_start = 1'b0;
    chk($sformatf("v%0d_latency", i), cyc, v.exp_lat);
    chk($sformatf("v%0d_ovr_at_done", i), ovr, v.exp_ovr);
    chk($sformatf("v%0d_busy_at_done", i), busy, 1);
    chk($sformatf("v%0d_dc_at_done", i), dc, v.dc);
    chk($sformatf("v%0d_cs_n_at_done", i), cs_n, 1);
    idle_bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (cs_n !== 1'b1 || busy !== 1'b0) idle_bad++;
    end
    #1;
    chk($sformatf("v%0d_idle_after", i), idle_bad, 0);
    chk($sformatf("v%0d_cs_low", i), cs_low_cnt - s_cs, v.exp_cs_low);
    chk($sformatf("v%0d_next_pulses", i), next_cnt - s_nb, v.exp_next);
    chk($sformatf("v%0d_done_pulses", i), done_cnt - s_done, 1);
    chk($sformatf("v%0d_ovr_pulses", i), ovr_cnt - s_ovr, {31'd0, v.exp_ovr});
    chk($sformatf("v%0d_protocol", i), viol_cnt - s_viol, 0);
    chk($sformatf("v%0d_nbytes", i), cap_q.size(), exp_q.size());
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      c = (cap_q.size() > 0) ? cap_q.pop_front() : 8'hxx;
      chk($sformatf("v%0d_byte%0d", i, k), c, e);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int r0, s_done, idle_bad;

    vecs[0] = mk(1'b0, DC_CMD,  1'b0, 1'b0, 1, 40'h00_00_00_00_AF, 1,  37,  35, 0, 1'b0);
    vecs[1] = mk(1'b0, DC_CMD,  1'b0, 1'b0, 3, 40'h00_00_5F_00_15, 3, 105, 103, 2, 1'b0);
    vecs[2] = mk(1'b0, DC_DATA, 1'b0, 1'b1, 2, 40'h00_00_00_3C_A5, 2,  71,  69, 1, 1'b0);
    vecs[3] = mk(1'b0, DC_CMD,  1'b1, 1'b0, 5, 40'hFF_18_24_42_81, 4, 139, 137, 3, 1'b1);
    vecs[4] = mk(1'b1, DC_CMD,  1'b0, 1'b0, 3, 40'h00_00_5F_00_15, 3,  57,  55, 2, 1'b0);
    for (int k = 0; k < 16; k++) buf_mem[k] = 8'h00;

    // Reset with i_start held: reset must win.
    i_reset = 1'b1;
    i_start = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_a", {a_sclk, a_cs_n, a_mosi, a_dc, a_busy, a_nb, a_done, a_ovr}, 8'b1100_0000);
    chk("reset_b", {b_sclk, b_cs_n, b_mosi, b_dc, b_busy, b_nb, b_done, b_ovr}, 8'b1100_0000);
    i_reset = 1'b0;
    i_start = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_after_reset", {cs_n, busy}, 2'b10);

    for (int i = 0; i < 5; i++) run_frame(i);

    // Let the CLK_DIV=2 instance finish the frame it ran in parallel.
    sel = 1'b0;
    for (int k = 0; k < 500 && a_busy !== 1'b0; k++) @(negedge clk);
    chk("drain_a", a_busy, 0);

    // i_start and i_reset in the same cycle.
    @(negedge clk);
    i_start = 1'b1;
    i_reset = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_reset = 1'b0;
    chk("start_with_reset", {cs_n, busy}, 2'b10);
    idle_bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (cs_n !== 1'b1 || busy !== 1'b0) idle_bad++;
    end
    chk("start_with_reset_idle", idle_bad, 0);

    // Reset during bit 4 of byte 2 of a 3-byte frame.
    load_vec(1);
    r0 = rise_total;
    s_done = done_cnt;
    @(negedge clk);
    i_start = 1'b1;
    i_dc    = DC_CMD;
    @(negedge clk);
    i_start = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      #1;
      if (rise_total - r0 == 11 && sclk === 1'b0) break;
    end
    chk("mid_reset_reach", rise_total - r0, 11);
    i_reset = 1'b1;
    @(negedge clk);
    #1;
    i_reset = 1'b0;
    chk("mid_reset_outputs", {cs_n, sclk, busy, done}, 4'b1100);
    idle_bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (cs_n !== 1'b1 || sclk !== 1'b1) idle_bad++;
    end
    #1;
    chk("mid_reset_idle", idle_bad, 0);
    chk("mid_reset_no_done", done_cnt - s_done, 0);
    for (int k = 0; k < 100 && b_busy !== 1'b0; k++) @(negedge clk);

    // Clean frame after the abort.
    run_frame(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, errs);
    $finish;
  end

  // Watchdog: the whole run is a few thousand cycles.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", errs);
    $fatal(1, "watchdog");
  end

endmodule
